cbit_frame_loader_icc: RTL and testbench
========================================

// Module: cbit_frame_loader_icc
// PURPOSE
// - Serial configuration loader that produces the cbit/cbitb/prog controls consumed by
//   in_mux/clk_mux/sbox style routing models.
// - Shifts in one NBITS frame and commits it atomically to complementary cbit/cbitb outputs.
// - Holds prog high while the fabric is unconfigured or being reloaded.
// - sdo daisy-chains to the next loader in the column.
// PARAMETERS
// - NBITS  default 6  number of config bits per frame (width of cbit/cbitb); NBITS >= 2
// PORTS
// - clk        input   1      loader clock; all state updates on the rising edge
// - rst        input   1      asynchronous, active-high reset
// - start      input   1      begin (or restart) a frame load
// - sdi        input   1      serial config data
// - sdi_valid  input   1      sdi carries a bit this cycle
// - sdi_ready  output  1      loader accepts a bit this cycle; transfer = sdi_valid & sdi_ready
// - sdo        output  1      shift_reg[NBITS-1], for daisy chain
// - cbit       output  NBITS  committed config bits
// - cbitb      output  NBITS  exact complement of cbit at all times
// - prog       output  1      1 = programming/unconfigured; downstream muxes tristate/force
// - done       output  1      one-cycle pulse on a successful commit
// - err        output  1      sticky frame error; cleared by start or rst
// BEHAVIOUR
// - Reset values (async): state=IDLE, shift_reg=0, bit_cnt=0, cbit=0, cbitb=all 1s,
//   prog=1, done=0, err=0, sdi_ready=0.
// - States: IDLE, SHIFT, CHECK (macro only), COMMIT, ERROR.
// - IDLE: sdi_ready=0. start -> SHIFT; bit_cnt<=0; err<=0; prog<=1 at the same edge.
// - SHIFT: sdi_ready=1. On transfer: shift_reg<={shift_reg[NBITS-2:0],sdi}; bit_cnt++.
//   The first bit sent lands in cbit[NBITS-1].
//   Transfer with bit_cnt==NBITS-1 -> CHECK (macro defined) or COMMIT.
// - bit_cnt width is $clog2(NBITS+1). It never wraps; it is cleared only by start or rst.
// - COMMIT: sdi_ready=0. At the edge leaving COMMIT:
//   - cbit<=shift_reg and cbitb<=~shift_reg, both in the same edge, so they are never non-complementary.
//   - prog<=0, done<=1 for one cycle, then -> IDLE.
// - Latency: last bit accepted at edge N; cbit valid, prog=0 and done=1 after edge N+1
//   (N+2 with the parity stage).
// - start in SHIFT/CHECK/ERROR: restart. bit_cnt<=0, err<=0, prog stays 1, cbit/cbitb keep
//   their old values. A bit offered in the same cycle is discarded; start wins.
// - start in COMMIT is ignored.
// - start in IDLE while configured: prog<=1 next edge; cbit holds until the next commit.
// - sdi_valid gaps: state and bit_cnt hold. sdi_valid outside SHIFT/CHECK is ignored.
// - ERROR: err=1, prog=1, cbit/cbitb unchanged, sdi_ready=0. Exit only via start or rst.
// - rst mid-frame: all reset values apply immediately, and the partial frame is lost.
// CONFIGURATION
// - CFG_PARITY_CHECK_EN defined:
//   - After the NBITS data bits, CHECK state (sdi_ready=1) accepts one even-parity bit.
//   - If (^shift_reg ^ sdi)==0 -> COMMIT.
//   - Otherwise -> ERROR with err<=1. The parity bit is not shifted into shift_reg or sdo.
// - CFG_PARITY_CHECK_EN undefined:
//   - The CHECK state does not exist; SHIFT goes straight to COMMIT and err is tied to 0.
// TESTING (NBITS=6)
// - Reset: rst=1 -> cbit=6'h00, cbitb=6'h3F, prog=1, done=0, err=0, sdi_ready=0;
//   sdi_valid=1 in IDLE changes nothing.
// - Load: start, then bits 1,0,1,1,0,1 (+parity 0 if macro) with valid every cycle ->
//   cbit=6'b101101, cbitb=6'b010010, prog=0, exactly one done pulse.
// - Bad parity (macro): frame 6'b101101 with parity 1 -> err=1, prog=1, cbit keeps its
//   prior value, no done. Then start -> err=0.
// - Restart: start, 3 bits, start again, frame 6'b000001 -> cbit=6'b000001.
//   The discarded partial bits never reach cbit.
// - Gaps and reset: random sdi_valid gaps on frame 6'b110011 -> cbit=6'b110011.
//   rst pulse after bit 4 of a later frame -> all reset values, cbit=0.
// - Reconfigure: with cbit=6'b101101, start -> prog=1 next cycle and cbit stays 6'b101101
//   until the new frame 6'b010101 commits. Check cbitb==~cbit on every cycle.

Source files
------------

// File: rtl/cbit_frame_loader_icc.sv
// Serial frame loader: shifts NBITS config bits in and commits them atomically to cbit/cbitb.
// Optional even-parity stage on each frame is enabled by defining CFG_PARITY_CHECK_EN.
module cbit_frame_loader_icc #(
  parameter int NBITS = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sdi,
  input  logic             i_sdi_valid,
  output logic             o_sdi_ready,
  output logic             o_sdo,
  output logic [NBITS-1:0] o_cbit,
  output logic [NBITS-1:0] o_cbitb,
  output logic             o_prog,
  output logic             o_done,
  output logic             o_err
);

  localparam int CW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, COMMIT, ERROR} state_t;

  state_t           r_state;
  logic [NBITS-1:0] r_shift_reg;
  logic [CW-1:0]    r_bit_cnt;
  logic [NBITS-1:0] r_cbit;
  logic             r_prog;
  logic             r_done;
  logic             r_sdi_ready;
  logic             w_xfer;
`ifdef CFG_PARITY_CHECK_EN
  logic             r_err;
`endif

  assign w_xfer = i_sdi_valid & r_sdi_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_shift_reg <= '0;
      r_bit_cnt   <= '0;
      r_cbit      <= '0;
      r_prog      <= 1'b1;
      r_done      <= 1'b0;
      r_sdi_ready <= 1'b0;
`ifdef CFG_PARITY_CHECK_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state     <= SHIFT;
            r_bit_cnt   <= '0;
            r_prog      <= 1'b1;
            r_sdi_ready <= 1'b1;
`ifdef CFG_PARITY_CHECK_EN
            r_err       <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          // start has priority over a bit offered in the same cycle
          if (i_start) begin
            r_bit_cnt <= '0;
          end else if (w_xfer) begin
            r_shift_reg <= {r_shift_reg[NBITS-2:0], i_sdi};
            r_bit_cnt   <= r_bit_cnt + CW'(1);
            if (r_bit_cnt == LAST_BIT) begin
`ifdef CFG_PARITY_CHECK_EN
              r_state     <= CHECK;
`else
              r_state     <= COMMIT;
              r_sdi_ready <= 1'b0;
`endif
            end
          end
        end
`ifdef CFG_PARITY_CHECK_EN
        CHECK: begin
          if (i_start) begin
            r_state   <= SHIFT;
            r_bit_cnt <= '0;
            r_err     <= 1'b0;
          end else if (w_xfer) begin
            r_sdi_ready <= 1'b0;
            if ((^r_shift_reg ^ i_sdi) == 1'b0) begin
              r_state <= COMMIT;
            end else begin
              r_state <= ERROR;
              r_err   <= 1'b1;
            end
          end
        end
        ERROR: begin
          if (i_start) begin
            r_state     <= SHIFT;
            r_bit_cnt   <= '0;
            r_err       <= 1'b0;
            r_sdi_ready <= 1'b1;
          end
        end
`endif
        COMMIT: begin
          r_cbit      <= r_shift_reg;
          r_prog      <= 1'b0;
          r_done      <= 1'b1;
          r_sdi_ready <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_state     <= IDLE;
          r_sdi_ready <= 1'b0;
        end
      endcase
    end
  end

  // cbitb is derived from the same register so it can never disagree with cbit
  assign o_cbit      = r_cbit;
  assign o_cbitb     = ~r_cbit;
  assign o_sdo       = r_shift_reg[NBITS-1];
  assign o_prog      = r_prog;
  assign o_done      = r_done;
  assign o_sdi_ready = r_sdi_ready;
`ifdef CFG_PARITY_CHECK_EN
  assign o_err       = r_err;
`else
  assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_cbit_frame_loader_icc.sv
// Directed self-checking bench for cbit_frame_loader_icc (NBITS=6), with or without CFG_PARITY_CHECK_EN.
module tb_cbit_frame_loader_icc;

   localparam int NBITS = 6;

   logic             i_clk = 1'b0;
   logic             i_rst = 1'b1;
   logic             i_start = 1'b0;
   logic             i_sdi = 1'b0;
   logic             i_sdi_valid = 1'b0;
   logic             o_sdi_ready;
   logic             o_sdo;
   logic [NBITS-1:0] o_cbit;
   logic [NBITS-1:0] o_cbitb;
   logic             o_prog;
   logic             o_done;
   logic             o_err;

   int checks = 0;
   int failures = 0;
   int doneCount = 0;
   bit monOn = 1'b0;

   cbit_frame_loader_icc #(.NBITS(NBITS)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_start     (i_start),
      .i_sdi       (i_sdi),
      .i_sdi_valid (i_sdi_valid),
      .o_sdi_ready (o_sdi_ready),
      .o_sdo       (o_sdo),
      .o_cbit      (o_cbit),
      .o_cbitb     (o_cbitb),
      .o_prog      (o_prog),
      .o_done      (o_done),
      .o_err       (o_err)
   );

   // Free-running 10 ns clock
   always #5 i_clk = ~i_clk;

   // Every cycle, between edges, cbitb must be the exact complement of cbit; done pulses are tallied
   always @(negedge i_clk) begin
      if (monOn) begin
         checks++;
         assert (o_cbitb === ~o_cbit) else begin
            failures++;
            $error("[TB] FAIL cbitb_complement: observed=%0h expected=%0h", o_cbitb, ~o_cbit);
         end
         if (o_done === 1'b1) doneCount++;
      end
   end

   // Advance one rising edge and settle just after it
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // One counted comparison of an observed value against a hand-computed expectation
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Offer one bit, waiting a bounded number of cycles for the loader to be ready
   task automatic sendBit(input logic b);
      int n;
      n = 0;
      i_sdi = b;
      i_sdi_valid = 1'b1;
      while (o_sdi_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checkOutput("sdi_ready_for_bit", {31'd0, o_sdi_ready}, 32'd1);
      tick();
      i_sdi_valid = 1'b0;
   endtask

   // Send one frame MSB first (optionally after a start and with idle gaps), plus parity when enabled
   task automatic applyStimulus(input logic [5:0] frame, input logic par, input bit gaps, input bit doStart);
      if (doStart) begin
         i_start = 1'b1;
         tick();
         i_start = 1'b0;
      end
      for (int i = NBITS - 1; i >= 0; i--) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               i_sdi_valid = 1'b0;
               i_sdi = ~frame[i];
               tick();
            end
         end
         sendBit(frame[i]);
      end
`ifdef CFG_PARITY_CHECK_EN
      sendBit(par);
`else
      i_sdi = par;
`endif
   endtask

   // Loader is in COMMIT: one edge later the frame must be live with a single done pulse
   task automatic commitCheck(input logic [5:0] frame, input string tag);
      int d0;
      checkOutput({tag, "_prog_before_commit"}, {31'd0, o_prog}, 32'd1);
      checkOutput({tag, "_done_before_commit"}, {31'd0, o_done}, 32'd0);
      d0 = doneCount;
      tick();
      checkOutput({tag, "_cbit"}, {26'd0, o_cbit}, {26'd0, frame});
      checkOutput({tag, "_cbitb"}, {26'd0, o_cbitb}, {26'd0, ~frame});
      checkOutput({tag, "_prog"}, {31'd0, o_prog}, 32'd0);
      checkOutput({tag, "_done"}, {31'd0, o_done}, 32'd1);
      tick();
      checkOutput({tag, "_done_cleared"}, {31'd0, o_done}, 32'd0);
      checkOutput({tag, "_done_pulses"}, doneCount - d0, 32'd1);
   endtask

   initial begin
      // Reset values
      tick();
      tick();
      monOn = 1'b1;
      checkOutput("rst_cbit", {26'd0, o_cbit}, 32'h00);
      checkOutput("rst_cbitb", {26'd0, o_cbitb}, 32'h3F);
      checkOutput("rst_prog", {31'd0, o_prog}, 32'd1);
      checkOutput("rst_done", {31'd0, o_done}, 32'd0);
      checkOutput("rst_err", {31'd0, o_err}, 32'd0);
      checkOutput("rst_ready", {31'd0, o_sdi_ready}, 32'd0);
      i_rst = 1'b0;

      // sdi_valid while idle is ignored
      i_sdi = 1'b1;
      i_sdi_valid = 1'b1;
      repeat (3) tick();
      i_sdi_valid = 1'b0;
      checkOutput("idle_ready", {31'd0, o_sdi_ready}, 32'd0);
      checkOutput("idle_sdo", {31'd0, o_sdo}, 32'd0);
      checkOutput("idle_cbit", {26'd0, o_cbit}, 32'h00);
      checkOutput("idle_prog", {31'd0, o_prog}, 32'd1);

      // Basic load of 101101
      applyStimulus(6'b101101, 1'b0, 1'b0, 1'b1);
      commitCheck(6'b101101, "load");
      checkOutput("load_sdo", {31'd0, o_sdo}, 32'd1);
      checkOutput("load_err", {31'd0, o_err}, 32'd0);

`ifdef CFG_PARITY_CHECK_EN
      // Bad parity: error raised, old frame kept, no done
      begin
         int d0;
         d0 = doneCount;
         applyStimulus(6'b101101, 1'b1, 1'b0, 1'b1);
         checkOutput("par_err", {31'd0, o_err}, 32'd1);
         checkOutput("par_prog", {31'd0, o_prog}, 32'd1);
         checkOutput("par_ready", {31'd0, o_sdi_ready}, 32'd0);
         tick();
         tick();
         checkOutput("par_err_sticky", {31'd0, o_err}, 32'd1);
         checkOutput("par_cbit_kept", {26'd0, o_cbit}, 32'h2D);
         checkOutput("par_no_done", doneCount - d0, 32'd0);
         i_start = 1'b1;
         tick();
         i_start = 1'b0;
         checkOutput("par_err_cleared", {31'd0, o_err}, 32'd0);
         checkOutput("par_restart_ready", {31'd0, o_sdi_ready}, 32'd1);
      end
`endif

      // Restart mid-frame; the bit offered alongside start is dropped
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      sendBit(1'b1);
      sendBit(1'b1);
      sendBit(1'b1);
      i_start = 1'b1;
      i_sdi = 1'b1;
      i_sdi_valid = 1'b1;
      tick();
      i_start = 1'b0;
      i_sdi_valid = 1'b0;
      checkOutput("restart_ready", {31'd0, o_sdi_ready}, 32'd1);
      checkOutput("restart_prog", {31'd0, o_prog}, 32'd1);
      checkOutput("restart_cbit_kept", {26'd0, o_cbit}, 32'h2D);
      applyStimulus(6'b000001, 1'b1, 1'b0, 1'b0);
      commitCheck(6'b000001, "restart");

      // Load with random valid gaps
      applyStimulus(6'b110011, 1'b0, 1'b1, 1'b1);
      commitCheck(6'b110011, "gaps");

      // Reset in the middle of a frame
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      sendBit(1'b1);
      sendBit(1'b0);
      sendBit(1'b1);
      sendBit(1'b0);
      i_rst = 1'b1;
      #1;
      checkOutput("midrst_cbit", {26'd0, o_cbit}, 32'h00);
      checkOutput("midrst_cbitb", {26'd0, o_cbitb}, 32'h3F);
      checkOutput("midrst_prog", {31'd0, o_prog}, 32'd1);
      checkOutput("midrst_ready", {31'd0, o_sdi_ready}, 32'd0);
      checkOutput("midrst_sdo", {31'd0, o_sdo}, 32'd0);
      checkOutput("midrst_done", {31'd0, o_done}, 32'd0);
      tick();
      i_rst = 1'b0;

      // Reconfigure: old frame stays live until the new one commits
      applyStimulus(6'b101101, 1'b0, 1'b0, 1'b1);
      commitCheck(6'b101101, "pre_reconf");
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      checkOutput("reconf_prog", {31'd0, o_prog}, 32'd1);
      checkOutput("reconf_cbit_hold", {26'd0, o_cbit}, 32'h2D);
      applyStimulus(6'b010101, 1'b1, 1'b0, 1'b0);
      checkOutput("reconf_cbit_hold_late", {26'd0, o_cbit}, 32'h2D);
      commitCheck(6'b010101, "reconf");

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
